// File: rtl/brute_force_matcher_match_arbiter.sv
// rtl/brute_force_matcher_match_arbiter.sv - per-engine 2-deep match FIFOs, round-robin arbiter and drain sequencer
`ifndef MATCH_INFO_WIDTH
`define MATCH_INFO_WIDTH 8
`endif

module brute_force_matcher_match_arbiter #(
    parameter int C_NUM_ENGINES = 4,
    parameter int C_ID_WIDTH    = 2
) (
    input  logic                                        compute_clk,
    input  logic                                        rst,
    input  logic                                        flush_req,
    input  logic [C_NUM_ENGINES-1:0]                    eng_match_info_valid,
    input  logic [C_NUM_ENGINES*`MATCH_INFO_WIDTH-1:0]  eng_match_info,
    output logic [C_NUM_ENGINES-1:0]                    eng_match_table_ready,
    output logic                                        tbl_match_info_valid,
    output logic [`MATCH_INFO_WIDTH-1:0]                tbl_match_info,
    output logic [C_ID_WIDTH-1:0]                       tbl_engine_id,
    input  logic                                        tbl_ready,
    output logic                                        flush_done,
    output logic [31:0]                                 match_count
);

    localparam int W = `MATCH_INFO_WIDTH;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Two-entry FIFO per engine: storage, pointers and occupancy
    logic [W-1:0]             fifo_mem [C_NUM_ENGINES][2];
    logic [C_NUM_ENGINES-1:0] fifo_wr_ptr;
    logic [C_NUM_ENGINES-1:0] fifo_rd_ptr;
    logic [1:0]               fifo_cnt [C_NUM_ENGINES];
    logic [C_NUM_ENGINES-1:0] fifo_empty;
    logic [C_NUM_ENGINES-1:0] fifo_push;
    logic [C_NUM_ENGINES-1:0] fifo_pop;

    // Arbitration
    logic [C_ID_WIDTH-1:0]    rr_ptr;
    logic [C_ID_WIDTH-1:0]    grant_idx;
    logic [C_ID_WIDTH-1:0]    grant_next_ptr;
    logic                     grant_found;
    logic                     out_load;
    int unsigned              arb_idx;

    state_t                   state;
    logic                     drain_ok;

    // Occupancy decode; ready depends only on FIFO flops, never on tbl_ready
    always_comb begin
        fifo_empty            = '0;
        eng_match_table_ready = '0;
        fifo_push             = '0;
        for (int i = 0; i < C_NUM_ENGINES; i++) begin
            fifo_empty[i]            = (fifo_cnt[i] == 2'd0);
            eng_match_table_ready[i] = (fifo_cnt[i] != 2'd2);
            fifo_push[i]             = eng_match_info_valid[i] && eng_match_table_ready[i];
        end
    end

    // Round-robin search: first non-empty engine at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        arb_idx     = 0;
        for (int k = 0; k < C_NUM_ENGINES; k++) begin
            arb_idx = 32'(rr_ptr) + 32'(k);
            if (arb_idx >= 32'(C_NUM_ENGINES)) begin
                arb_idx = arb_idx - 32'(C_NUM_ENGINES);
            end
            if (!grant_found && !fifo_empty[arb_idx[C_ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = arb_idx[C_ID_WIDTH-1:0];
            end
        end
    end

    // Output stage reloads whenever it is empty or being consumed
    always_comb begin
        out_load = !tbl_match_info_valid || tbl_ready;
        fifo_pop = '0;
        if (out_load && grant_found) begin
            fifo_pop[grant_idx] = 1'b1;
        end
        if (32'(grant_idx) == 32'(C_NUM_ENGINES - 1)) begin
            grant_next_ptr = '0;
        end else begin
            grant_next_ptr = grant_idx + 1'b1;
        end
        drain_ok = (&fifo_empty) && (!tbl_match_info_valid || tbl_ready);
    end

    // FIFO push/pop bookkeeping; simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge compute_clk) begin
        for (int i = 0; i < C_NUM_ENGINES; i++) begin
            if (rst) begin
                fifo_cnt[i]    <= 2'd0;
                fifo_wr_ptr[i] <= 1'b0;
                fifo_rd_ptr[i] <= 1'b0;
            end else begin
                if (fifo_push[i]) begin
                    fifo_mem[i][fifo_wr_ptr[i]] <= eng_match_info[i*W +: W];
                    fifo_wr_ptr[i]              <= ~fifo_wr_ptr[i];
                end
                if (fifo_pop[i]) begin
                    fifo_rd_ptr[i] <= ~fifo_rd_ptr[i];
                end
                case ({fifo_push[i], fifo_pop[i]})
                    2'b10:   fifo_cnt[i] <= fifo_cnt[i] + 2'd1;
                    2'b01:   fifo_cnt[i] <= fifo_cnt[i] - 2'd1;
                    default: fifo_cnt[i] <= fifo_cnt[i];
                endcase
            end
        end
    end

    // Registered output stage and round-robin pointer
    always_ff @(posedge compute_clk) begin
        if (rst) begin
            tbl_match_info_valid <= 1'b0;
            tbl_match_info       <= '0;
            tbl_engine_id        <= '0;
            rr_ptr               <= '0;
        end else if (out_load) begin
            if (grant_found) begin
                tbl_match_info_valid <= 1'b1;
                tbl_match_info       <= fifo_mem[grant_idx][fifo_rd_ptr[grant_idx]];
                tbl_engine_id        <= grant_idx;
                rr_ptr               <= grant_next_ptr;
            end else begin
                tbl_match_info_valid <= 1'b0;
            end
        end
    end

    // Count matches accepted by the table; wraps naturally
    always_ff @(posedge compute_clk) begin
        if (rst) begin
            match_count <= '0;
        end else if (tbl_match_info_valid && tbl_ready) begin
            match_count <= match_count + 32'd1;
        end
    end

    // Drain sequencer: ACTIVE -> DRAIN -> DONE (one-cycle flush_done pulse)
    always_ff @(posedge compute_clk) begin
        if (rst) begin
            state      <= ST_ACTIVE;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                ST_ACTIVE: begin
                    if (flush_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_ok) begin
                        state      <= ST_DONE;
                        flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= flush_req ? ST_DRAIN : ST_ACTIVE;
                end
                default: begin
                    state <= ST_ACTIVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brute_force_matcher_match_arbiter.sv
// tb/tb_brute_force_matcher_match_arbiter.sv - directed and random checks of the match arbiter against a queue model
`ifndef MATCH_INFO_WIDTH
`define MATCH_INFO_WIDTH 8
`endif

module tb_brute_force_matcher_match_arbiter;

    localparam int N = 4;
    localparam int W = `MATCH_INFO_WIDTH;

    logic             compute_clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush_req = 1'b0;
    logic [N-1:0]     eng_match_info_valid = '0;
    logic [N*W-1:0]   eng_match_info;
    logic [N-1:0]     eng_match_table_ready;
    logic             tbl_match_info_valid;
    logic [W-1:0]     tbl_match_info;
    logic [1:0]       tbl_engine_id;
    logic             tbl_ready = 1'b1;
    logic             flush_done;
    logic [31:0]      match_count;

    logic [W-1:0]     ed [N];

    always #5 compute_clk = ~compute_clk;

    always_comb begin
        eng_match_info = '0;
        for (int i = 0; i < N; i++) eng_match_info[i*W +: W] = ed[i];
    end

    brute_force_matcher_match_arbiter #(.C_NUM_ENGINES(N), .C_ID_WIDTH(2)) dut (
        .compute_clk           (compute_clk),
        .rst                   (rst),
        .flush_req             (flush_req),
        .eng_match_info_valid  (eng_match_info_valid),
        .eng_match_info        (eng_match_info),
        .eng_match_table_ready (eng_match_table_ready),
        .tbl_match_info_valid  (tbl_match_info_valid),
        .tbl_match_info        (tbl_match_info),
        .tbl_engine_id         (tbl_engine_id),
        .tbl_ready             (tbl_ready),
        .flush_done            (flush_done),
        .match_count           (match_count)
    );

    // Reference model: queues per engine, one output slot, a pointer and a phase
    logic [W-1:0] mq [N][$];
    bit           m_valid;
    logic [W-1:0] m_info;
    int           m_id, m_ptr, m_state;
    logic [31:0]  m_count;
    bit           m_done;
    bit           wrap_req = 0;
    bit           mb_empty, mb_free;
    bit [N-1:0]   mb_push;
    int           mb_g, mb_idx;

    always @(posedge compute_clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 0; m_info = '0; m_id = 0; m_ptr = 0;
            m_count = 0; m_state = 0; m_done = 0;
        end else begin
            mb_empty = 1;
            for (int i = 0; i < N; i++) if (mq[i].size() != 0) mb_empty = 0;
            mb_free = !m_valid || tbl_ready;
            for (int i = 0; i < N; i++) mb_push[i] = eng_match_info_valid[i] && (mq[i].size() < 2);
            if (wrap_req) m_count = 32'hFFFF_FFFF;
            if (m_valid && tbl_ready) m_count = m_count + 1;
            m_done = 0;
            if (m_state == 0) begin
                if (flush_req) m_state = 1;
            end else if (m_state == 1) begin
                if (mb_empty && mb_free) begin m_state = 2; m_done = 1; end
            end else begin
                m_state = flush_req ? 1 : 0;
            end
            if (mb_free) begin
                mb_g = -1;
                for (int k = 0; k < N; k++) begin
                    mb_idx = (m_ptr + k) % N;
                    if (mb_g < 0 && mq[mb_idx].size() > 0) mb_g = mb_idx;
                end
                if (mb_g >= 0) begin
                    m_info = mq[mb_g].pop_front();
                    m_id = mb_g; m_valid = 1; m_ptr = (mb_g + 1) % N;
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < N; i++) if (mb_push[i]) mq[i].push_back(ed[i]);
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit [N-1:0] last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) er[i] = (mq[i].size() < 2);
        chk("valid", 64'(tbl_match_info_valid), 64'(m_valid));
        if (m_valid) begin
            chk("info", 64'(tbl_match_info), 64'(m_info));
            chk("id", 64'(tbl_engine_id), 64'(m_id));
        end
        chk("ready", 64'(eng_match_table_ready), 64'(er));
        chk("flush_done", 64'(flush_done), 64'(m_done));
        chk("match_count", 64'(match_count), 64'(m_count));
    endtask

    task automatic step();
        for (int i = 0; i < N; i++) last_acc[i] = eng_match_info_valid[i] && (mq[i].size() < 2);
        @(posedge compute_clk);
        cyc++;
        @(negedge compute_clk);
        check_all();
    endtask

    // Engines keep valid/data until accepted, then pick new random traffic
    task automatic rand_engines(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!eng_match_info_valid[i] || last_acc[i]) begin
                eng_match_info_valid[i] = ($urandom_range(0, 99) < pct);
                ed[i] = W'($urandom);
            end
        end
    endtask

    int idcnt [N];
    logic [W-1:0] got [$];
    int p, acc_n, acc5_cyc, done_cyc, pulses, mn, mx;

    initial begin
        for (int i = 0; i < N; i++) ed[i] = '0;
        last_acc = '0;
        @(negedge compute_clk);
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 64'(tbl_match_info_valid), 64'd0);
        chk("rst_ready", 64'(eng_match_table_ready), 64'hF);
        chk("rst_info", 64'(tbl_match_info), 64'd0);
        chk("rst_id", 64'(tbl_engine_id), 64'd0);
        chk("rst_done", 64'(flush_done), 64'd0);
        chk("rst_count", 64'(match_count), 64'd0);

        // single push from engine 2
        eng_match_info_valid = 4'b0100; ed[2] = 8'hA5;
        step();
        eng_match_info_valid = '0;
        chk("single_t1_valid", 64'(tbl_match_info_valid), 64'd0);
        step();
        chk("single_valid", 64'(tbl_match_info_valid), 64'd1);
        chk("single_info", 64'(tbl_match_info), 64'hA5);
        chk("single_id", 64'(tbl_engine_id), 64'd2);
        step();
        chk("single_count", 64'(match_count), 64'd1);

        // fairness: all engines valid continuously, pointer sits at 3
        for (int i = 0; i < N; i++) idcnt[i] = 0;
        eng_match_info_valid = '0;
        rand_engines(100);
        step(); rand_engines(100);
        step(); rand_engines(100);
        for (int k = 0; k < 40; k++) begin
            chk("fair_valid", 64'(tbl_match_info_valid), 64'd1);
            chk("fair_id", 64'(tbl_engine_id), 64'((3 + k) % N));
            idcnt[tbl_engine_id]++;
            step(); rand_engines(100);
        end
        mn = idcnt[0]; mx = idcnt[0];
        for (int i = 1; i < N; i++) begin
            if (idcnt[i] < mn) mn = idcnt[i];
            if (idcnt[i] > mx) mx = idcnt[i];
        end
        chk("fair_spread_le1", 64'(mx - mn <= 1), 64'd1);
        eng_match_info_valid = '0;
        for (int k = 0; k < 12; k++) step();

        // backpressure: engine 0 streams three matches into a stalled table
        tbl_ready = 1'b0;
        p = 0;
        for (int k = 0; k < 8; k++) begin
            if (p < 3) begin eng_match_info_valid[0] = 1'b1; ed[0] = 8'h10 + 8'(p); end
            else eng_match_info_valid[0] = 1'b0;
            step();
            if (last_acc[0]) p++;
        end
        eng_match_info_valid = '0;
        chk("bp_pushes", 64'(p), 64'd3);
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready0", 64'(eng_match_table_ready[0]), 64'd0);
            chk("bp_hold", 64'(tbl_match_info), 64'h10);
            step();
        end
        tbl_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 6; k++) begin
            if (tbl_match_info_valid && tbl_ready) got.push_back(tbl_match_info);
            step();
        end
        chk("bp_n", 64'(got.size()), 64'd3);
        for (int k = 0; k < got.size() && k < 3; k++) chk("bp_order", 64'(got[k]), 64'(8'h10 + 8'(k)));

        // drain with five queued matches and toggling tbl_ready
        tbl_ready = 1'b0;
        eng_match_info_valid = 4'b0111; ed[0] = 8'h20; ed[1] = 8'h21; ed[2] = 8'h22;
        step();
        eng_match_info_valid = 4'b0011; ed[0] = 8'h23; ed[1] = 8'h24;
        step();
        eng_match_info_valid = '0;
        step();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        acc_n = 0; acc5_cyc = -100; done_cyc = -1; pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tbl_ready = (k % 2 == 0);
            if (m_valid && tbl_ready) begin
                acc_n++;
                if (acc_n == 5) acc5_cyc = cyc;
            end
            step();
            if (flush_done) begin pulses++; done_cyc = cyc; end
        end
        chk("drain_accepts", 64'(acc_n), 64'd5);
        chk("drain_pulses", 64'(pulses), 64'd1);
        chk("drain_timing", 64'(done_cyc), 64'(acc5_cyc + 1));
        tbl_ready = 1'b1;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("eflush_t1", 64'(flush_done), 64'd0);
        step();
        chk("eflush_t2", 64'(flush_done), 64'd1);
        step();
        chk("eflush_t3", 64'(flush_done), 64'd0);

        // reset with queued data and a valid output
        tbl_ready = 1'b0;
        eng_match_info_valid = 4'b0011; ed[0] = 8'h31; ed[1] = 8'h32;
        step();
        ed[0] = 8'h33; ed[1] = 8'h34;
        step();
        eng_match_info_valid = '0;
        chk("mrst_pre_valid", 64'(tbl_match_info_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid", 64'(tbl_match_info_valid), 64'd0);
        chk("mrst_ready", 64'(eng_match_table_ready), 64'hF);
        chk("mrst_count", 64'(match_count), 64'd0);
        tbl_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mrst_no_stale", 64'(tbl_match_info_valid), 64'd0);
        end

        // match_count wrap
        tbl_ready = 1'b0;
        eng_match_info_valid = 4'b0100; ed[2] = 8'h66;
        step();
        eng_match_info_valid = '0;
        step();
        force dut.match_count = 32'hFFFF_FFFF;
        #1;
        release dut.match_count;
        chk("wrap_pre", 64'(match_count), 64'hFFFF_FFFF);
        wrap_req = 1;
        tbl_ready = 1'b1;
        step();
        wrap_req = 0;
        chk("wrap_zero", 64'(match_count), 64'd0);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            tbl_ready = ($urandom_range(0, 99) < 70);
            flush_req = ($urandom_range(0, 99) < 5);
            rand_engines(50);
            step();
        end
        flush_req = 1'b0;
        eng_match_info_valid = '0;
        tbl_ready = 1'b1;
        for (int k = 0; k < 12; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
